pipe_stall_ctrl: RTL

//  Control-side counterpart of the 5-stage pipeline register walls: generates enable_regwalls,
//  do_hazard and do_flush_REG1 instead of consuming them. Merges instruction/data memory
//  req/ack handshakes, load-use hazard detection and branch-flush bookkeeping into one

---
 rtl/pipe_stall_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_detect.sv | 24 ++
 rtl/pipe_stall_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline control definitions: stall FSM state encoding and the
// hard-wired zero register index.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use compare between the EX-stage load destination and
// the ID-stage source registers.
module pipe_hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic       ex_do_dm_read,
  input  logic [4:0] ex_write_reg_addr,
  input  logic [4:0] id_ra_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_ra,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic ra_match;
  logic rt_match;

  assign ra_match = id_uses_ra & (id_ra_addr == ex_write_reg_addr);
  assign rt_match = id_uses_rt & (id_rt_addr == ex_write_reg_addr);

  // Register zero is never written, so a load targeting it cannot create a dependency.
  assign load_use = ex_do_dm_read & (ex_write_reg_addr != REG_ZERO) & (ra_match | rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges memory handshakes, load-use hazards and
// branch-flush bookkeeping into the register-wall enables, with a timeout watchdog.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic             im_req,
  input  logic             im_ack,
  input  logic             mem_dm_read,
  input  logic             mem_dm_write,
  output logic             dm_req,
  input  logic             dm_ack,
  input  logic [4:0]       id_ra_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_ra,
  input  logic             id_uses_rt,
  input  logic             ex_do_dm_read,
  input  logic [4:0]       ex_write_reg_addr,
  input  logic             ex_branch_taken,
  output logic             enable_regwalls,
  output logic             do_hazard,
  output logic             do_flush_REG1,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state;
  logic             im_done;
  logic             dm_done;
  logic             flush_pending;
  logic             mem_error_q;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] stall_q;

  logic active;
  logic need_dm;
  logic im_ok;
  logic dm_ok;
  logic advance;
  logic load_use;
  logic stall_event;

  pipe_hazard_detect u_hazard (
    .ex_do_dm_read     (ex_do_dm_read),
    .ex_write_reg_addr (ex_write_reg_addr),
    .id_ra_addr        (id_ra_addr),
    .id_rt_addr        (id_rt_addr),
    .id_uses_ra        (id_uses_ra),
    .id_uses_rt        (id_uses_rt),
    .load_use          (load_use)
  );

  // Reset gates every output so the walls never see a stale request or enable.
  assign active  = (state != ERROR) & ~reset;
  assign need_dm = mem_dm_read | mem_dm_write;
  assign im_ok   = im_ack | im_done;
  assign dm_ok   = ~need_dm | dm_ack | dm_done;
  assign advance = active & im_ok & dm_ok;

  assign enable_regwalls = advance;
  assign im_req          = active & ~im_done;
  assign dm_req          = active & need_dm & ~dm_done;
  assign do_hazard       = load_use & advance;
  // A hazard holds REG1, so a pending flush must wait for the next advancing cycle.
  assign do_flush_REG1   = (ex_branch_taken | flush_pending) & advance & ~load_use;
  assign mem_error       = mem_error_q & ~reset;
  assign stall_cycles    = reset ? '0 : stall_q;

  assign stall_event = (~advance | do_hazard) & (state != ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      im_done       <= 1'b0;
      dm_done       <= 1'b0;
      flush_pending <= 1'b0;
      wait_cnt      <= '0;
      mem_error_q   <= 1'b0;
      stall_q       <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!advance) begin
            im_done  <= im_done | im_ack;
            dm_done  <= dm_done | dm_ack;
            wait_cnt <= WC_W'(1);
            state    <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (advance) begin
            im_done  <= 1'b0;
            dm_done  <= 1'b0;
            wait_cnt <= '0;
            state    <= RUN;
          end else begin
            im_done <= im_done | im_ack;
            dm_done <= dm_done | dm_ack;
            if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
              state       <= ERROR;
              mem_error_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
          end
        end
        ERROR: begin
          mem_error_q <= 1'b1;
        end
        default: state <= RUN;
      endcase

      if (state != ERROR) begin
        if (do_flush_REG1)
          flush_pending <= 1'b0;
        else if (ex_branch_taken)
          flush_pending <= 1'b1;
      end

      if (stall_event && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule
